// File: rtl/div20_arb_pkg.sv
// Shared constants for the round-robin divide-by-20 arbiter: FSM encoding,
// shift-add term table and pipeline depth.
package div20_arb_pkg;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   localparam int PIPE_DEPTH     = 3;
   localparam int N_PSUM         = 4;
   localparam int TERMS_PER_PSUM = 4;
   localparam int ROUND_BIT      = 4;

   // x * 1.6 as a sum of right shifts; the final >>5 turns it into x / 20
   localparam int SHIFT_K [N_PSUM*TERMS_PER_PSUM] = '{
      0, 1, 4, 5, 8, 9, 12, 13, 16, 17, 20, 21, 24, 25, 28, 29
   };

endpackage

// File: rtl/div20_pipe2.sv
// Shift-add divide-by-20 datapath: operand register, partial-sum register and
// rounded output register, with a valid/id sideband riding alongside.
module div20_pipe2
   import div20_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IN_W  = 37,
   parameter int OUT_W = 32,
   parameter int ID_W  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [ID_W-1:0]         in_id,
   input  logic signed [IN_W-1:0]  in_data,
   output logic [N_REQ-1:0]        out_valid,
   output logic [OUT_W-1:0]        out_data,
   output logic [ID_W-1:0]         out_id,
   output logic                    busy
);

   localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

   logic                   s0_valid_r;
   logic [ID_W-1:0]        s0_id_r;
   logic signed [IN_W-1:0] s0_data_r;
   logic                   s1_valid_r;
   logic [ID_W-1:0]        s1_id_r;
   logic signed [IN_W-1:0] s1_psum_r [N_PSUM];
   logic [N_REQ-1:0]       out_valid_r;
   logic [OUT_W-1:0]       out_data_r;
   logic [ID_W-1:0]        out_id_r;

   logic signed [IN_W-1:0] psum_s [N_PSUM];
   logic signed [IN_W-1:0] total_s;
   logic [OUT_W-1:0]       result_s;

   // Four partial sums of four arithmetic-shift terms each
   always_comb begin
      for (int g = 0; g < N_PSUM; g++) begin
         psum_s[g] = '0;
         for (int j = 0; j < TERMS_PER_PSUM; j++) begin
            psum_s[g] = psum_s[g] + (s0_data_r >>> SHIFT_K[g*TERMS_PER_PSUM + j]);
         end
      end
   end

   // Final sum, divide by 32 and round half-up on the first discarded bit
   always_comb begin
      total_s  = s1_psum_r[0] + s1_psum_r[1] + s1_psum_r[2] + s1_psum_r[3];
      result_s = total_s[ROUND_BIT+1 +: OUT_W] + OUT_W'(total_s[ROUND_BIT]);
   end

   // Pipeline registers; payload only loads when its stage is valid
   always_ff @(posedge clk) begin
      if (reset) begin
         s0_valid_r  <= 1'b0;
         s0_id_r     <= '0;
         s0_data_r   <= '0;
         s1_valid_r  <= 1'b0;
         s1_id_r     <= '0;
         for (int g = 0; g < N_PSUM; g++) begin
            s1_psum_r[g] <= '0;
         end
         out_valid_r <= '0;
         out_data_r  <= '0;
         out_id_r    <= '0;
      end else begin
         s0_valid_r <= in_valid;
         if (in_valid) begin
            s0_id_r   <= in_id;
            s0_data_r <= in_data;
         end
         s1_valid_r <= s0_valid_r;
         if (s0_valid_r) begin
            s1_id_r <= s0_id_r;
            for (int g = 0; g < N_PSUM; g++) begin
               s1_psum_r[g] <= psum_s[g];
            end
         end
         out_valid_r <= s1_valid_r ? (ONE_HOT0 << s1_id_r) : '0;
         if (s1_valid_r) begin
            out_id_r   <= s1_id_r;
            out_data_r <= result_s;
         end
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_id    = out_id_r;
   assign busy      = s0_valid_r | s1_valid_r | (|out_valid_r);

endmodule

// File: rtl/div20_share_arb.sv
// Round-robin arbiter sharing one divide-by-20 pipeline among N_REQ requesters,
// with hold/drain quiescing. Optional counters under DIV20_ARB_STATS_EN.
module div20_share_arb
   import div20_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IN_W  = 37,
   parameter int OUT_W = 32,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*IN_W-1:0]   req_data,
   output logic [N_REQ-1:0]        req_ready,
   input  logic                    hold,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [OUT_W-1:0]        rsp_data,
   output logic [ID_W-1:0]         rsp_id,
   output logic                    busy,
   output logic                    drained
`ifdef DIV20_ARB_STATS_EN
   ,
   output logic [N_REQ*16-1:0]     grant_cnt,
   output logic [15:0]             stall_cnt
`endif
);

   localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

   logic [1:0]      state_r;
   logic [1:0]      next_state_s;
   logic [ID_W-1:0] rr_ptr_r;
   logic [ID_W-1:0] rr_nxt_s;
   logic [ID_W-1:0] grant_idx_s;
   logic            found_s;
   logic [N_REQ-1:0] grant_s;
   logic signed [IN_W-1:0] sel_data_s;

   // Round-robin search starting at rr_ptr, gated off outside RUN or under hold
   always_comb begin
      int              idx;
      logic [ID_W-1:0] cur;
      logic            hit;
      idx         = 0;
      cur         = '0;
      hit         = 1'b0;
      found_s     = 1'b0;
      grant_idx_s = '0;
      if ((state_r == ST_RUN) && !hold) begin
         for (int off = 0; off < N_REQ; off++) begin
            idx         = int'(rr_ptr_r) + off;
            idx         = (idx >= N_REQ) ? (idx - N_REQ) : idx;
            cur         = ID_W'(idx);
            hit         = !found_s && req_valid[cur];
            grant_idx_s = hit ? cur : grant_idx_s;
            found_s     = found_s | hit;
         end
      end else begin
         found_s = 1'b0;
      end
      grant_s = found_s ? (ONE_HOT0 << grant_idx_s) : '0;
   end

   assign rr_nxt_s   = (int'(grant_idx_s) == N_REQ - 1) ? '0 : (grant_idx_s + ID_W'(1));
   assign sel_data_s = req_data[grant_idx_s*IN_W +: IN_W];
   assign req_ready  = grant_s;

   // Quiesce FSM: an empty pipe lets hold go straight to HALT
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (hold) begin
               next_state_s = busy ? ST_DRAIN : ST_HALT;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (!hold) begin
               next_state_s = ST_RUN;
            end else if (!busy) begin
               next_state_s = ST_HALT;
            end else begin
               next_state_s = ST_DRAIN;
            end
         end
         ST_HALT: begin
            if (!hold) begin
               next_state_s = ST_RUN;
            end else begin
               next_state_s = ST_HALT;
            end
         end
         default: next_state_s = ST_RUN;
      endcase
   end

   // FSM state and round-robin pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ST_RUN;
         rr_ptr_r <= '0;
      end else begin
         state_r <= next_state_s;
         if (found_s) begin
            rr_ptr_r <= rr_nxt_s;
         end
      end
   end

   assign drained = (state_r == ST_HALT);

   div20_pipe2 #(
      .N_REQ (N_REQ),
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .ID_W  (ID_W)
   ) u_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (found_s),
      .in_id     (grant_idx_s),
      .in_data   (sel_data_s),
      .out_valid (rsp_valid),
      .out_data  (rsp_data),
      .out_id    (rsp_id),
      .busy      (busy)
   );

`ifdef DIV20_ARB_STATS_EN
   logic [15:0] grant_cnt_r [N_REQ];
   logic [15:0] stall_cnt_r;

   // Per-requester saturating acceptance counts and wrapping stall count
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_REQ; i++) begin
            grant_cnt_r[i] <= 16'd0;
         end
         stall_cnt_r <= 16'd0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (grant_s[i] && (grant_cnt_r[i] != 16'hFFFF)) begin
               grant_cnt_r[i] <= grant_cnt_r[i] + 16'd1;
            end
         end
         if ((|req_valid) && !found_s) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
         end
      end
   end

   // Flatten counters onto the packed output
   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < N_REQ; i++) begin
         grant_cnt[i*16 +: 16] = grant_cnt_r[i];
      end
   end

   assign stall_cnt = stall_cnt_r;
`endif

endmodule
